// File: rtl/btn_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_evt_pkg
// Description : Shared event codes, FSM state encoding and key-decode helpers
//               for the push-button event generator.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_evt_pkg;

    localparam logic [1:0] EV_INC = 2'd0;
    localparam logic [1:0] EV_DEC = 2'd1;
    localparam logic [1:0] EV_CLR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_e;

    // True when exactly one key is pressed
    function automatic logic is_single(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Maps a single-key pattern onto its event code (btn[3] never reaches here)
    function automatic logic [1:0] key_code(input logic [3:0] v);
        logic [1:0] code;
        case (v)
            4'b0001: code = EV_INC;
            4'b0010: code = EV_DEC;
            default: code = EV_CLR;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : One-bit 2-FF synchroniser (active-low input) followed by a
//               stability counter; the output level only changes after
//               DEB_CYCLES consecutive samples disagree with it.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_held
);

    localparam int             CW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]  C_CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          held_q;
    logic          held_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          w_sample;

    // Stability counter: count while the synced sample disagrees, toggle at terminal count
    always_comb begin
        w_sample = ~sync2_q;
        held_d   = held_q;
        cnt_d    = '0;
        if (w_sample != held_q) begin
            if (cnt_q == C_CNT_MAX) begin
                held_d = ~held_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser resets to the released level so no false press follows reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            held_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_btn_n;
            sync2_q <= sync1_q;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_held = held_q;

endmodule
`default_nettype wire

// File: rtl/btn_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_gen
// Description : Debounces four active-low buttons and turns single-key presses
//               into one-cycle INC/DEC/CLR events with hold-to-repeat and a
//               long-press clear.
//               Optional macro BTN_EVT_ACCEL_EN: after 8 repeat events the
//               repeat interval shrinks to TICK_DIV/4 until the key leaves
//               the repeat state.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_event_gen
    import btn_evt_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000,
    parameter int TICK_DIV   = 8388608,
    parameter int HOLD_TICKS = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] btn,
    output logic [3:0] held,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    output logic       ev_repeat
);

    localparam int            TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int            HW          = $clog2(HOLD_TICKS + 1);
    localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLD_TICKS - 1);
`ifdef BTN_EVT_ACCEL_EN
    // Fast interval is kept at 2 or more so ev_valid can never be back-to-back
    localparam int            FAST_DIV    = ((TICK_DIV / 4) > 1) ? (TICK_DIV / 4) : 2;
    localparam logic [TW-1:0] C_TICK_FAST = TW'(FAST_DIV - 1);
    localparam logic [3:0]    C_ACC_AFTER = 4'd8;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_deb
            btn_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk     (CLK),
                .rst     (RST),
                .i_btn_n (btn[gi]),
                .o_held  (held[gi])
            );
        end
    endgenerate

    state_e        state_q,     state_d;
    logic [TW-1:0] tick_q,      tick_d;
    logic [HW-1:0] hold_q,      hold_d;
    logic [3:0]    key_q,       key_d;
    logic          ev_valid_q,  ev_valid_d;
    logic [1:0]    ev_code_q,   ev_code_d;
    logic          ev_repeat_q, ev_repeat_d;
    logic [TW-1:0] w_tick_last;
    logic          w_tick_wrap;
`ifdef BTN_EVT_ACCEL_EN
    logic [3:0]    acc_q,       acc_d;
`endif

    // Next-state, tick/hold counting and event generation
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        hold_d      = hold_q;
        key_d       = key_q;
        ev_valid_d  = 1'b0;
        ev_code_d   = ev_code_q;
        ev_repeat_d = ev_repeat_q;
`ifdef BTN_EVT_ACCEL_EN
        acc_d       = acc_q;
        w_tick_last = ((state_q == ST_REPEAT) && (acc_q == C_ACC_AFTER)) ? C_TICK_FAST : C_TICK_LAST;
`else
        w_tick_last = C_TICK_LAST;
`endif
        w_tick_wrap = (tick_q == w_tick_last);

        case (state_q)
            ST_IDLE: begin
                if (held != 4'd0) begin
                    if (is_single(held) && !held[3]) begin
                        key_d   = held;
                        tick_d  = '0;
                        hold_d  = '0;
                        state_d = ST_HOLD;
                        // Clear key only acts on long press, so no initial event
                        if (!held[2]) begin
                            ev_valid_d  = 1'b1;
                            ev_code_d   = key_code(held);
                            ev_repeat_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_WAIT_REL;
                    end
                end
            end

            ST_HOLD, ST_REPEAT: begin
                if (held == 4'd0) begin
                    state_d = ST_IDLE;
                end else if (held != key_q) begin
                    state_d = ST_WAIT_REL;
                end else if (!w_tick_wrap) begin
                    tick_d = tick_q + 1'b1;
                end else begin
                    tick_d = '0;
                    if (state_q == ST_REPEAT) begin
                        ev_valid_d  = 1'b1;
                        ev_code_d   = key_code(key_q);
                        ev_repeat_d = 1'b1;
`ifdef BTN_EVT_ACCEL_EN
                        if (acc_q != C_ACC_AFTER) begin
                            acc_d = acc_q + 4'd1;
                        end
`endif
                    end else if (hold_q == C_HOLD_LAST) begin
                        ev_valid_d = 1'b1;
                        ev_code_d  = key_code(key_q);
                        if (key_q[2]) begin
                            ev_repeat_d = 1'b0;
                            state_d     = ST_WAIT_REL;
                        end else begin
                            ev_repeat_d = 1'b1;
                            state_d     = ST_REPEAT;
`ifdef BTN_EVT_ACCEL_EN
                            acc_d       = 4'd1;
`endif
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end

            ST_WAIT_REL: begin
                if (held == 4'd0) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef BTN_EVT_ACCEL_EN
        // Acceleration history only survives while the key stays in REPEAT
        if (state_d != ST_REPEAT) begin
            acc_d = 4'd0;
        end
`endif
    end

    // FSM and registered outputs; reset drops any pending event silently
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            hold_q      <= '0;
            key_q       <= 4'd0;
            ev_valid_q  <= 1'b0;
            ev_code_q   <= 2'd0;
            ev_repeat_q <= 1'b0;
`ifdef BTN_EVT_ACCEL_EN
            acc_q       <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            hold_q      <= hold_d;
            key_q       <= key_d;
            ev_valid_q  <= ev_valid_d;
            ev_code_q   <= ev_code_d;
            ev_repeat_q <= ev_repeat_d;
`ifdef BTN_EVT_ACCEL_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign ev_valid  = ev_valid_q;
    assign ev_code   = ev_code_q;
    assign ev_repeat = ev_repeat_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_gen
// Description : Directed bench for btn_event_gen (DEB_CYCLES=4, TICK_DIV=8,
//               HOLD_TICKS=3). Stimulus pushes expected events, tagged with the
//               cycle they must appear on, into a queue; a monitor pops and
//               compares on every ev_valid.
//               Timing reference: a key driven at the negedge where cyc==N is
//               seen by the FSM at posedge N+7, so its initial event is sampled
//               at cyc==N+7 and the first repeat at N+31.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_gen;
    import btn_evt_pkg::*;

`ifdef BTN_EVT_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    typedef struct {
        logic [1:0] code;
        logic       rep;
        int         cyc;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] btn = 4'hF;
    logic [3:0] held;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       ev_repeat;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic prev_v   = 1'b0;

    btn_event_gen #(
        .DEB_CYCLES (4),
        .TICK_DIV   (8),
        .HOLD_TICKS (3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .btn       (btn),
        .held      (held),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_repeat (ev_repeat)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] code, input logic rep, input int at);
        exp_t e;
        e.code = code;
        e.rep  = rep;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Press a single INC/DEC key for hold_len cycles, expecting the initial
    // event plus every repeat that falls before the FSM sees the release.
    task automatic press_hold(input logic [3:0] pat, input logic [1:0] code, input int hold_len);
        int n;
        int t;
        int k;
        btn = pat;
        n   = cyc;
        push(code, 1'b0, n + 7);
        t = n + 31;
        k = 1;
        while (t <= n + hold_len + 6) begin
            push(code, 1'b1, t);
            t = t + ((ACCEL && k >= 8) ? 2 : 8);
            k++;
        end
        wait_cyc(hold_len);
        chk("held_level", int'(held), int'(~pat & 4'hF));
        btn = 4'hF;
        wait_cyc(20);
        chk("held_released", int'(held), 0);
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge CLK) begin
        if (ev_valid) begin
            if (prev_v) chk("ev_valid_back_to_back", 1, 0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got code=%0d repeat=%0d at cycle %0d, expected no event",
                         ev_code, ev_repeat, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ev_code",   int'(ev_code),   int'(e.code));
                chk("ev_repeat", int'(ev_repeat), int'(e.rep));
                chk("ev_cycle",  cyc,             e.cyc);
            end
        end
        prev_v <= ev_valid;
    end

    initial begin
        int n;

        // Reset state
        wait_cyc(3);
        chk("rst_held",      int'(held),      0);
        chk("rst_ev_valid",  int'(ev_valid),  0);
        chk("rst_ev_code",   int'(ev_code),   0);
        chk("rst_ev_repeat", int'(ev_repeat), 0);
        RST = 1'b0;
        wait_cyc(10);

        // 1: INC held 60 cycles -> initial + 5 repeats
        press_hold(4'b1110, EV_INC, 60);

        // 2: 2-cycle glitch on btn[1] must be rejected
        btn = 4'b1101;
        wait_cyc(2);
        btn = 4'hF;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(1);
            chk("glitch_held", int'(held), 0);
        end
        wait_cyc(10);

        // 3a: short press of the clear key emits nothing
        btn = 4'b1011;
        wait_cyc(20);
        chk("clr_short_held", int'(held), 4);
        btn = 4'hF;
        wait_cyc(20);

        // 3b: long press of the clear key -> one CLR, no repeats
        btn = 4'b1011;
        n   = cyc;
        push(EV_CLR, 1'b0, n + 31);
        wait_cyc(40);
        btn = 4'hF;
        wait_cyc(20);

        // 4: two keys together are ignored, then a clean DEC
        btn = 4'b1100;
        wait_cyc(20);
        chk("two_key_held", int'(held), 3);
        btn = 4'hF;
        wait_cyc(20);
        press_hold(4'b1101, EV_DEC, 10);

        // 5: reset while repeating, key still held afterwards
        btn = 4'b1110;
        n   = cyc;
        push(EV_INC, 1'b0, n + 7);
        push(EV_INC, 1'b1, n + 31);
        wait_cyc(35);
        RST = 1'b1;
        wait_cyc(1);
        chk("mid_rst_held",      int'(held),      0);
        chk("mid_rst_ev_valid",  int'(ev_valid),  0);
        chk("mid_rst_ev_code",   int'(ev_code),   0);
        chk("mid_rst_ev_repeat", int'(ev_repeat), 0);
        RST = 1'b0;
        push(EV_INC, 1'b0, n + 43);
        wait_cyc(14);
        btn = 4'hF;
        wait_cyc(20);

        // 6: long INC hold (accelerates after 8 repeats when enabled)
        press_hold(4'b1110, EV_INC, 150);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
